// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
// Module : fetch_ctrl_pkg
// Brief  : Shared types and constants for the instruction-fetch controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_ctrl_pkg;

  localparam int          FETCH_ADDR_W = 64;
  localparam int          FETCH_INSN_W = 32;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_INSN_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
    logic                    misalign;
  } fetch_data_t;

  typedef struct packed {
    logic                    valid;
    logic [FETCH_ADDR_W-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic                    data_ok;
    logic [FETCH_INSN_W-1:0] data;
  } ibus_resp_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buf.sv
// ============================================================================
// Module : fetch_buf
// Brief  : One-entry holding buffer with load/clear and async active-low reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int           W       = 8,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_data;

  // Clear wins over load so a redirect can never leave a stale word behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= CLR_VAL;
    end else if (i_clear) begin
      r_data <= CLR_VAL;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module : fetch_ctrl
// Brief  : Instruction-fetch controller: PC -> bus request -> {instr, pc} to F/D.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter int                ADDR_W   = 64,
  parameter int                INSN_W   = 32,
  parameter logic [INSN_W-1:0] NOP_INSN = fetch_ctrl_pkg::NOP_INSN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic              stallD,
  output logic              ireq_valid,
  output logic [ADDR_W-1:0] ireq_addr,
  input  logic              iresp_data_ok,
  input  logic [INSN_W-1:0] iresp_data,
  output logic              stallI,
  output logic              instr_valid,
  output logic [INSN_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_misalign
);

  import fetch_ctrl_pkg::*;

  localparam int                BUF_W   = INSN_W + ADDR_W + 1;
  localparam logic [BUF_W-1:0]  BUF_CLR = {NOP_INSN, {ADDR_W{1'b0}}, 1'b0};

  fetch_state_t      r_state;
  fetch_state_t      w_next;
  logic [ADDR_W-1:0] r_drop_addr;

  logic              w_misaligned;
  logic              w_req_valid;
  logic [ADDR_W-1:0] w_req_addr;
  logic              w_stall;
  logic              w_valid;
  logic [INSN_W-1:0] w_instr;
  logic [ADDR_W-1:0] w_pc;
  logic              w_mis;
  logic              w_buf_load;
  logic              w_buf_clear;
  logic              w_drop_load;
  logic [BUF_W-1:0]  w_buf_q;

  assign w_misaligned = (pc[1:0] != 2'b00);

  fetch_buf #(
    .W       (BUF_W),
    .CLR_VAL (BUF_CLR)
  ) u_buf (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_data  ({w_instr, w_pc, w_mis}),
    .o_data  (w_buf_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_REQ;
      r_drop_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_drop_load) begin
        r_drop_addr <= pc;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_req_valid = 1'b0;
    w_req_addr  = pc;
    w_stall     = 1'b1;
    w_valid     = 1'b0;
    w_instr     = NOP_INSN;
    w_pc        = '0;
    w_mis       = 1'b0;
    w_buf_load  = 1'b0;
    w_buf_clear = 1'b0;
    w_drop_load = 1'b0;

    unique case (r_state)
      S_REQ: begin
        if (w_misaligned) begin
          w_valid = 1'b1;
          w_mis   = 1'b1;
          w_pc    = pc;
          w_stall = stallD;
          w_next  = stallD ? S_HOLD : S_REQ;
          w_buf_load = stallD;
        end else begin
          w_req_valid = 1'b1;
          if (iresp_data_ok) begin
            w_valid    = 1'b1;
            w_instr    = iresp_data;
            w_pc       = pc;
            w_stall    = stallD;
            w_next     = stallD ? S_HOLD : S_REQ;
            w_buf_load = stallD;
          end
        end
        // A redirect with a request still in flight must swallow its response.
        if (jump) begin
          w_stall     = 1'b0;
          w_valid     = 1'b0;
          w_buf_load  = 1'b0;
          w_drop_load = !w_misaligned && !iresp_data_ok;
          w_next      = w_drop_load ? S_DROP : S_REQ;
        end
      end
      S_HOLD: begin
        {w_instr, w_pc, w_mis} = w_buf_q;
        w_valid = 1'b1;
        w_stall = stallD;
        w_next  = stallD ? S_HOLD : S_REQ;
        if (jump) begin
          w_stall     = 1'b0;
          w_valid     = 1'b0;
          w_buf_clear = 1'b1;
          w_next      = S_REQ;
        end
      end
      S_DROP: begin
        w_req_valid = 1'b1;
        w_req_addr  = r_drop_addr;
        w_next      = iresp_data_ok ? S_REQ : S_DROP;
        if (jump) begin
          w_stall = 1'b0;
        end
      end
      default: begin
        w_next = S_REQ;
      end
    endcase
  end

  assign ireq_valid     = reset & w_req_valid;
  assign ireq_addr      = w_req_addr;
  assign stallI         = ~reset | w_stall;
  assign instr_valid    = reset & w_valid;
  assign instr          = instr_valid ? w_instr : NOP_INSN;
  assign instr_pc       = instr_valid ? w_pc : '0;
  assign instr_misalign = instr_valid & w_mis;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic        jump;
  logic        stallD;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stallI;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_misalign;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .jump           (jump),
    .stallD         (stallD),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .stallI         (stallI),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_misalign (instr_misalign)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Scoreboard monitor: pops one expected entry per word accepted by F/D.
  always @(negedge clk) begin
    if (reset && instr_valid && !stallD) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got instr=%h pc=%h mis=%b, required no output",
                 instr, instr_pc, instr_misalign);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (instr !== e.instr || instr_pc !== e.pc || instr_misalign !== e.mis) begin
          bad++;
          $display("FAIL sb_word: got instr=%h pc=%h mis=%b, required instr=%h pc=%h mis=%b",
                   instr, instr_pc, instr_misalign, e.instr, e.pc, e.mis);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic setin(input logic [63:0] p, input logic j, input logic sd,
                       input logic ok, input logic [31:0] d,
                       input logic push = 1'b0, input logic [31:0] ei = 32'h0,
                       input logic [63:0] ep = 64'h0, input logic em = 1'b0);
    exp_t e;
    pc = p; jump = j; stallD = sd; iresp_data_ok = ok; iresp_data = d;
    if (push) begin
      e.instr = ei; e.pc = ep; e.mis = em;
      q.push_back(e);
    end
  endtask

  task automatic step(input logic [63:0] p, input logic j, input logic sd,
                      input logic ok, input logic [31:0] d,
                      input logic push = 1'b0, input logic [31:0] ei = 32'h0,
                      input logic [63:0] ep = 64'h0, input logic em = 1'b0);
    @(posedge clk);
    #1;
    setin(p, j, sd, ok, d, push, ei, ep, em);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    setin(64'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_stallI", stallI, 1);
    chk("rst_ireq_valid", ireq_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 64'h13);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_misalign", instr_misalign, 0);

    // Test 1: three waiting cycles, then the word passes straight through.
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(64'h8000_0000, 0, 0, 0, 32'h0);
      chk("t1_req_valid", ireq_valid, 1);
      chk("t1_req_addr", ireq_addr, 64'h8000_0000);
      chk("t1_stallI", stallI, 1);
      chk("t1_no_valid", instr_valid, 0);
    end
    step(64'h8000_0000, 0, 0, 1, 32'h00A0_0093, 1, 32'h00A0_0093, 64'h8000_0000, 0);
    chk("t1_stallI_done", stallI, 0);
    chk("t1_valid", instr_valid, 1);

    // Test 2: response lands while decode is stalled, held until release.
    step(64'h8000_0004, 0, 0, 0, 32'h0);
    chk("t2_req_addr", ireq_addr, 64'h8000_0004);
    step(64'h8000_0004, 0, 1, 1, 32'h0010_0113);
    chk("t2_ok_stallI", stallI, 1);
    chk("t2_ok_instr", instr, 32'h0010_0113);
    step(64'h8000_0004, 0, 1, 0, 32'h0);
    chk("t2_hold_req", ireq_valid, 0);
    chk("t2_hold_instr", instr, 32'h0010_0113);
    chk("t2_hold_pc", instr_pc, 64'h8000_0004);
    chk("t2_hold_stallI", stallI, 1);
    step(64'h8000_0004, 0, 0, 0, 32'h0, 1, 32'h0010_0113, 64'h8000_0004, 0);
    chk("t2_release_stallI", stallI, 0);
    chk("t2_release_req", ireq_valid, 0);
    step(64'h8000_0008, 0, 0, 0, 32'h0);
    chk("t2_next_req", ireq_valid, 1);
    chk("t2_next_addr", ireq_addr, 64'h8000_0008);

    // Test 3: jump on the second cycle of a four-cycle request.
    step(64'h8000_0008, 1, 0, 0, 32'h0);
    chk("t3_jump_stallI", stallI, 0);
    chk("t3_jump_valid", instr_valid, 0);
    step(64'h8000_1000, 0, 0, 0, 32'h0);
    chk("t3_drop_req", ireq_valid, 1);
    chk("t3_drop_addr", ireq_addr, 64'h8000_0008);
    chk("t3_drop_stallI", stallI, 1);
    step(64'h8000_1000, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t3_drop_addr2", ireq_addr, 64'h8000_0008);
    chk("t3_discard", instr_valid, 0);
    step(64'h8000_1000, 0, 0, 0, 32'h0);
    chk("t3_target_addr", ireq_addr, 64'h8000_1000);
    step(64'h8000_1000, 0, 0, 1, 32'h0020_0193, 1, 32'h0020_0193, 64'h8000_1000, 0);

    // Test 4: jump coincident with data_ok.
    step(64'h8000_1004, 0, 0, 0, 32'h0);
    chk("t4_req_addr", ireq_addr, 64'h8000_1004);
    step(64'h8000_1004, 1, 0, 1, 32'hBADB_AD00);
    chk("t4_valid", instr_valid, 0);
    chk("t4_stallI", stallI, 0);
    step(64'h8000_2000, 0, 0, 0, 32'h0);
    chk("t4_target_req", ireq_valid, 1);
    chk("t4_target_addr", ireq_addr, 64'h8000_2000);
    step(64'h8000_2000, 0, 0, 1, 32'h0030_0213, 1, 32'h0030_0213, 64'h8000_2000, 0);

    // Test 5: misaligned PC.
    step(64'h8000_0002, 0, 0, 0, 32'h0, 1, 32'h0000_0013, 64'h8000_0002, 1);
    chk("t5_no_req", ireq_valid, 0);
    chk("t5_misalign", instr_misalign, 1);
    chk("t5_instr", instr, 64'h13);
    chk("t5_stallI", stallI, 0);

    // Test 6: reset asserted while draining a dropped request.
    step(64'h8000_3000, 0, 0, 0, 32'h0);
    step(64'h8000_3000, 1, 0, 0, 32'h0);
    step(64'h8000_4000, 0, 0, 0, 32'h0);
    chk("t6_drop_addr", ireq_addr, 64'h8000_3000);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", instr_valid, 0);
    chk("t6_rst_req", ireq_valid, 0);
    chk("t6_rst_stallI", stallI, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    step(64'h8000_4000, 0, 0, 0, 32'h0);
    chk("t6_fresh_req", ireq_valid, 1);
    chk("t6_fresh_addr", ireq_addr, 64'h8000_4000);
    step(64'h8000_4000, 0, 0, 1, 32'h0040_0293, 1, 32'h0040_0293, 64'h8000_4000, 0);
    step(64'h8000_4004, 0, 0, 0, 32'h0);

    chk("sb_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
